// File: rtl/task_pkg.sv
// Shared types and constants for the task record path between the serial
// receiver, the record FIFO and the minimization core.
package task_pkg;

  typedef struct packed {
    logic [0:31] data;
    logic [2:0]  capacity;
    logic [2:0]  error;
  } task_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_DIGIT = 3'd1;
  localparam logic [2:0] ERR_COUNT = 3'd2;
  localparam logic [2:0] CAP_MIN   = 3'd3;
  localparam logic [2:0] CAP_MAX   = 3'd5;

endpackage

// File: rtl/task_fifo_mem.sv
// Record storage: DEPTH slots of task_t, one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module task_fifo_mem
  import task_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  task_t            wdata,
  input  logic [PTR_W-1:0] raddr,
  output task_t            rdata
);

  task_t mem_q [DEPTH];

  // Slot write on accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Show-ahead read of the head slot.
  always_comb begin
    rdata = mem_q[raddr];
  end

endmodule

// File: rtl/task_fifo.sv
// Show-ahead record FIFO: pushes on the rising edge of in_write, presents the
// head record over valid/ready and counts records dropped while full.
module task_fifo
  import task_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [0:31]              in_data,
  input  logic [2:0]               in_capacity,
  input  logic [2:0]               in_error,
  input  logic                     in_write,
  output logic [0:31]              out_data,
  output logic [2:0]               out_capacity,
  output logic [2:0]               out_error,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              write_q, write_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DROP_W-1:0] drop_base_s;
  logic              push_s, pop_s, accept_s, drop_s;
  task_t             wr_rec_s, head_s;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    if (v == {DROP_W{1'b1}}) begin
      return v;
    end else begin
      return v + DROP_W'(1);
    end
  endfunction

  task_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (accept_s),
    .waddr (wr_ptr_q),
    .wdata (wr_rec_s),
    .raddr (rd_ptr_q),
    .rdata (head_s)
  );

  // Handshake decode, pointer/count update and drop accounting.
  always_comb begin
    write_d  = in_write;
    push_s   = in_write & ~write_q;
    pop_s    = ~empty_q & out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
    accept_s = push_s & (~full_q | pop_s);
    drop_s   = push_s & full_q & ~pop_s;
    wr_rec_s = '{data: in_data, capacity: in_capacity, error: in_error};

    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == CNT_W'(0));

    // Clear takes effect before a coincident drop is counted.
    if (ovf_clr) begin
      drop_base_s = {DROP_W{1'b0}};
    end else begin
      drop_base_s = drop_cnt_q;
    end
    if (drop_s) begin
      overflow_d = 1'b1;
      drop_cnt_d = sat_inc(drop_base_s);
    end else begin
      overflow_d = overflow_q & ~ovf_clr;
      drop_cnt_d = drop_base_s;
    end
  end

  // State registers; write_q resets high so a level held through reset never pushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q    <= 1'b1;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_W{1'b0}};
    end else begin
      write_q    <= write_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Head record, forced to zero while empty.
  always_comb begin
    if (empty_q) begin
      out_data     = 32'd0;
      out_capacity = 3'd0;
      out_error    = 3'd0;
    end else begin
      out_data     = head_s.data;
      out_capacity = head_s.capacity;
      out_error    = head_s.error;
    end
    out_valid = ~empty_q;
    count     = count_q;
    full      = full_q;
    empty     = empty_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
  end

endmodule

// File: tb/tb_task_fifo.sv
// Directed bench for task_fifo: edge-triggered push, ordering, overflow
// accounting, full push+pop, saturation/clear and asynchronous reset.
module tb_task_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:31] in_data;
  logic [2:0]  in_capacity;
  logic [2:0]  in_error;
  logic        in_write;
  logic [0:31] out_data;
  logic [2:0]  out_capacity;
  logic [2:0]  out_error;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        ovf_clr;

  int vectors = 0;
  int miscompares = 0;

  task_fifo #(.DEPTH(4), .DROP_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_capacity  (in_capacity),
    .in_error     (in_error),
    .in_write     (in_write),
    .out_data     (out_data),
    .out_capacity (out_capacity),
    .out_error    (out_error),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .drop_cnt     (drop_cnt),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two-cycle push: rising write edge, then write back low.
  task automatic push(input logic [31:0] d, input logic [2:0] cap, input logic [2:0] err);
    in_data     = d;
    in_capacity = cap;
    in_error    = err;
    in_write    = 1'b1;
    tick();
    in_write    = 1'b0;
    in_data     = 32'd0;
    in_capacity = 3'd0;
    in_error    = 3'd0;
    tick();
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] d);
    check(tag, {63'd0, out_valid}, 64'd1);
    check(tag, {32'd0, out_data}, {32'd0, d});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_data = 32'd0; in_capacity = 3'd0; in_error = 3'd0;
    in_write = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_count", {61'd0, count}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_data", {32'd0, out_data}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);

    // Level held high 3 cycles gives one push
    in_data = 32'hA5A50F0F; in_capacity = 3'd5; in_error = 3'd0; in_write = 1'b1;
    tick();
    check("lat_valid", {63'd0, out_valid}, 64'd1);
    tick(); tick();
    in_write = 1'b0;
    tick();
    check("lvl_count", {61'd0, count}, 64'd1);
    check("lvl_data", {32'd0, out_data}, 64'hA5A50F0F);
    check("lvl_cap", {61'd0, out_capacity}, 64'd5);
    pop_expect("lvl_pop", 32'hA5A50F0F);
    check("lvl_empty", {63'd0, empty}, 64'd1);

    // Five pushes into four slots, error record kept verbatim
    push(32'd1, 3'd3, 3'd0);
    push(32'd2, 3'd3, 3'd2);
    check("err_stored", {61'd0, out_error}, 64'd0);
    push(32'd3, 3'd3, 3'd0);
    push(32'd4, 3'd3, 3'd0);
    check("ovf_before", {63'd0, overflow}, 64'd0);
    push(32'd5, 3'd3, 3'd0);
    check("ovf_full", {63'd0, full}, 64'd1);
    check("ovf_count", {61'd0, count}, 64'd4);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    check("ovf_drops", {56'd0, drop_cnt}, 64'd1);
    pop_expect("drain1", 32'd1);
    check("drain2_err", {61'd0, out_error}, 64'd2);
    pop_expect("drain2", 32'd2);
    pop_expect("drain3", 32'd3);
    pop_expect("drain4", 32'd4);
    check("drain_empty", {63'd0, empty}, 64'd1);
    check("drain_zero", {32'd0, out_data}, 64'd0);

    // Full with push and pop in the same cycle
    push(32'h21, 3'd4, 3'd0);
    push(32'h22, 3'd4, 3'd0);
    push(32'h23, 3'd4, 3'd0);
    push(32'h24, 3'd4, 3'd0);
    in_data = 32'h11; in_capacity = 3'd3; in_write = 1'b1; out_ready = 1'b1;
    tick();
    in_write = 1'b0; out_ready = 1'b0;
    tick();
    check("pp_count", {61'd0, count}, 64'd4);
    check("pp_full", {63'd0, full}, 64'd1);
    check("pp_drops", {56'd0, drop_cnt}, 64'd1);
    // Ready held high: one record per cycle
    check("stream0", {32'd0, out_data}, 64'h22);
    out_ready = 1'b1;
    tick(); check("stream1", {32'd0, out_data}, 64'h23);
    tick(); check("stream2", {32'd0, out_data}, 64'h24);
    tick(); check("stream3", {32'd0, out_data}, 64'h11);
    tick(); out_ready = 1'b0;
    check("stream_empty", {63'd0, empty}, 64'd1);

    // Saturation, clear, and clear coincident with a drop
    for (int i = 0; i < 4; i++) push(32'h30 + 32'(i), 3'd5, 3'd0);
    for (int i = 0; i < 260; i++) push(32'hDEAD, 3'd5, 3'd0);
    check("sat_drops", {56'd0, drop_cnt}, 64'd255);
    check("sat_ovf", {63'd0, overflow}, 64'd1);
    check("sat_head", {32'd0, out_data}, 64'h30);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("clr_ovf", {63'd0, overflow}, 64'd0);
    check("clr_drops", {56'd0, drop_cnt}, 64'd0);
    tick();
    ovf_clr = 1'b1; in_write = 1'b1;
    tick();
    ovf_clr = 1'b0; in_write = 1'b0;
    check("clrdrop_ovf", {63'd0, overflow}, 64'd1);
    check("clrdrop_cnt", {56'd0, drop_cnt}, 64'd1);
    check("clrdrop_count", {61'd0, count}, 64'd4);
    tick();

    // Async reset while write level is held high
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    check("pre_rst_empty", {63'd0, empty}, 64'd1);
    push(32'h41, 3'd3, 3'd0);
    in_data = 32'h42; in_capacity = 3'd3; in_write = 1'b1;
    tick();
    check("pre_rst_count", {61'd0, count}, 64'd2);
    #2 rst = 1'b1;
    #1;
    check("arst_count", {61'd0, count}, 64'd0);
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_data", {32'd0, out_data}, 64'd0);
    check("arst_empty", {63'd0, empty}, 64'd1);
    #1 rst = 1'b0;
    tick(); tick(); tick();
    check("held_nopush", {61'd0, count}, 64'd0);
    in_write = 1'b0;
    tick();
    in_data = 32'h77; in_capacity = 3'd4; in_write = 1'b1;
    tick();
    in_write = 1'b0;
    check("repush_count", {61'd0, count}, 64'd1);
    check("repush_data", {32'd0, out_data}, 64'h77);
    check("repush_cap", {61'd0, out_capacity}, 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
